// File: rtl/program_sequencer_if.sv
// program_sequencer_if: load/start/abort controls and issue outputs of program_sequencer.
//   master drives load_en, load_addr[3:0], load_data[3:0], start, abort (and step with SEQ_SINGLE_STEP_EN)
//   slave drives instruction[3:0], instr_valid, pc[3:0], busy, done, instr_count[4:0]
interface program_sequencer_if;
  logic load_en, start, abort, instr_valid, busy, done;
  logic [3:0] load_addr, load_data, instruction, pc;
  logic [4:0] instr_count;
`ifdef SEQ_SINGLE_STEP_EN
  logic step;
  modport master (output load_en, load_addr, load_data, start, abort, step,
                  input instruction, instr_valid, pc, busy, done, instr_count);
  modport slave (input load_en, load_addr, load_data, start, abort, step,
                 output instruction, instr_valid, pc, busy, done, instr_count);
`else
  modport master (output load_en, load_addr, load_data, start, abort,
                  input instruction, instr_valid, pc, busy, done, instr_count);
  modport slave (input load_en, load_addr, load_data, start, abort,
                 output instruction, instr_valid, pc, busy, done, instr_count);
`endif
endinterface

// File: rtl/program_sequencer.sv
// program_sequencer: 16x4 program memory stepped out to an instruction decoder, one opcode per two cycles.
//   clk, rst_n (async active-low); bus: program_sequencer_if.slave (load port, start/abort, issue outputs)
//   SEQ_SINGLE_STEP_EN adds bus.step and a WAIT_STEP state between FETCH and ISSUE.
module program_sequencer (
  input  logic clk,
  input  logic rst_n,
  program_sequencer_if.slave bus
);
  localparam logic [3:0] HALT = 4'hF, NOP = 4'hC;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_STEP, ISSUE, DONE} state_t;
  state_t state, next;
  logic [3:0] mem [16];
  logic [3:0] ir, pc, op, instruction;
  logic [4:0] cnt;
  logic instr_valid, done;
  always_ff @(posedge clk)
    if (bus.load_en && state == IDLE) mem[bus.load_addr] <= bus.load_data;
  // opcode heading for ISSUE: straight from memory in FETCH, from ir when leaving WAIT_STEP
  assign op = state == FETCH ? mem[pc] : ir;
  // HALT retires directly from fetch (or the step wait), so Done follows the last issue by two cycles
  always_comb begin
    next = state;
    case (state)
      IDLE:      next = bus.start ? FETCH : IDLE;
`ifdef SEQ_SINGLE_STEP_EN
      FETCH:     next = WAIT_STEP;
      WAIT_STEP: next = !bus.step ? WAIT_STEP : ir == HALT ? DONE : ISSUE;
`else
      FETCH:     next = op == HALT ? DONE : ISSUE;
`endif
      ISSUE:     next = pc == 4'd15 ? DONE : FETCH;
      default:   next = IDLE;
    endcase
    if (bus.abort && state != IDLE) next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      cnt         <= '0;
      ir          <= NOP;
      instruction <= NOP;
      instr_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= next;
      instr_valid <= next == ISSUE;
      instruction <= next == ISSUE ? op : NOP;
      done        <= next == DONE;
      if (state == FETCH) ir <= mem[pc];
      if (state == IDLE && bus.start) begin
        pc  <= '0;
        cnt <= '0;
      end
      if (state == ISSUE) begin
        cnt <= cnt + 5'd1;
        if (pc != 4'd15 && !bus.abort) pc <= pc + 4'd1;
      end
    end
  assign bus.instruction = instruction;
  assign bus.instr_valid = instr_valid;
  assign bus.pc          = pc;
  assign bus.busy        = state != IDLE;
  assign bus.done        = done;
  assign bus.instr_count = cnt;
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: table-driven, hand-sequenced and random checks of program_sequencer against a schedule model.
module tb_program_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  program_sequencer_if bus();
  program_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0, failures = 0, obs_done, seen;
  logic [3:0] shadow [16];
  typedef struct {int halt_pos; int base; int exp_cnt; int exp_pc; int exp_done;} vec_t;
  vec_t vecs [5];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  task automatic load(input logic [3:0] a, input logic [3:0] d);
    bus.load_en = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    tick();
    bus.load_en = 1'b0;
    shadow[a] = d;
  endtask
  // Expected schedule: entry j issues on cycle 2+2j; a HALT at j gives Done on 2+2j; no HALT gives Done on 33.
  task automatic run(input bit ld, input logic [3:0] la, input logic [3:0] lv);
    int done_c, issued, last_pc;
    logic ev [41];
    logic [3:0] eop [41];
    done_c = 33;
    issued = 0;
    last_pc = 15;
    if (ld) shadow[la] = lv;
    foreach (ev[i]) begin
      ev[i] = 1'b0;
      eop[i] = 4'hC;
    end
    for (int j = 0; j < 16; j++) begin
      if (shadow[j] == 4'hF) begin
        done_c = 2 + 2 * j;
        last_pc = j;
        break;
      end
      ev[2 + 2 * j] = 1'b1;
      eop[2 + 2 * j] = shadow[j];
      issued++;
    end
    bus.start = 1'b1;
    if (ld) begin
      bus.load_en = 1'b1;
      bus.load_addr = la;
      bus.load_data = lv;
    end
    obs_done = -1;
    for (int c = 1; c <= done_c + 1; c++) begin
      tick();
      bus.start = 1'b0;
      bus.load_en = 1'b0;
      if (bus.done && obs_done < 0) obs_done = c;
      chk($sformatf("run_cycle%0d", c), {bus.busy, bus.done, bus.instr_valid, bus.instruction},
          {c <= done_c, c == done_c, ev[c], eop[c]});
    end
    chk("run_pc", bus.pc, last_pc);
    chk("run_cnt", bus.instr_count, issued);
  endtask
  initial begin
    bus.load_en = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    bus.step = 1'b0;
`endif
    #12;
    chk("reset_outputs", {bus.busy, bus.done, bus.instr_valid, bus.instruction, bus.pc, bus.instr_count},
        {1'b0, 1'b0, 1'b0, 4'hC, 4'h0, 5'h0});
    @(negedge clk);
    rst_n = 1'b1;
    tick();
`ifdef SEQ_SINGLE_STEP_EN
    load(0, 4'h2);
    load(1, 4'hF);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      seen += bus.instr_valid;
    end
    chk("step_hold_valid", seen, 0);
    chk("step_hold_pc", bus.pc, 0);
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    chk("step_issue", {bus.instr_valid, bus.instruction}, {1'b1, 4'h2});
    seen = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      seen += bus.instr_valid;
    end
    chk("step_one_valid", seen, 1);
    chk("step_wait_busy", bus.busy, 1);
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    chk("step_halt_done", bus.done, 1);
`else
    vecs = '{'{0, 3, 0, 0, 2}, '{1, 5, 1, 1, 4}, '{7, 0, 7, 7, 16}, '{15, 9, 15, 15, 32}, '{16, 2, 16, 15, 33}};
    foreach (vecs[i]) begin
      for (int a = 0; a < 16; a++)
        load(4'(a), a == vecs[i].halt_pos ? 4'hF : 4'((vecs[i].base + a) % 15));
      run(1'b0, 4'h0, 4'h0);
      chk($sformatf("tbl%0d_done_cycle", i), obs_done, vecs[i].exp_done);
      chk($sformatf("tbl%0d_cnt", i), bus.instr_count, vecs[i].exp_cnt);
      chk($sformatf("tbl%0d_pc", i), bus.pc, vecs[i].exp_pc);
    end
    load(0, 4'h0);
    load(1, 4'h1);
    load(2, 4'h2);
    load(3, 4'h4);
    load(4, 4'hF);
    run(1'b0, 4'h0, 4'h0);
    chk("basic_done_cycle", obs_done, 10);
    chk("basic_cnt", bus.instr_count, 4);
    chk("basic_pc", bus.pc, 4);
    for (int a = 0; a < 5; a++) load(4'(a), 4'(a + 1));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_second_valid", bus.instr_valid, 1);
    tick();
    seen = bus.done;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    seen += bus.done;
    chk("abort_busy", bus.busy, 0);
    chk("abort_no_done", seen, 0);
    chk("abort_cnt", bus.instr_count, 2);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.load_en = 1'b1;
    bus.load_addr = 4'h0;
    bus.load_data = 4'h3;
    tick();
    tick();
    bus.load_en = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("busy_load_idle", bus.busy, 0);
    run(1'b0, 4'h0, 4'h0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("reset_issue_valid", bus.instr_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_async", {bus.busy, bus.done, bus.instr_valid, bus.instruction, bus.pc, bus.instr_count},
        {1'b0, 1'b0, 1'b0, 4'hC, 4'h0, 5'h0});
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("reset_waits_start", bus.busy, 0);
    run(1'b0, 4'h0, 4'h0);
    run(1'b1, 4'h0, 4'h6);
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 16; a++) load(4'(a), 4'($urandom_range(0, 15)));
      run(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Clock  input  1  Single system clock; all state updates on rising edge.
REQ-002 Reset_n  input  1  Asynchronous, active-low reset.
REQ-003 LoadEn  input  1  Write strobe for program memory.
REQ-004 LoadAddr  input  4  Program memory write address.
REQ-005 LoadData  input  4  Program memory write data (one opcode).
REQ-006 Start  input  1  Begin execution at address 0; single-cycle pulse.
REQ-007 Abort  input  1  Terminate execution immediately.
REQ-008 Instruction  output  4  Opcode to instruction decoder, registered.
REQ-009 InstrValid  output  1  High for exactly the cycle Instruction carries a live opcode.
REQ-010 PC  output  4  Current program counter.
REQ-011 Busy  output  1  High in any state other than IDLE.
REQ-012 Done  output  1  One-cycle pulse on normal completion (HALT or end of memory).
REQ-013 InstrCount  output  5  Opcodes issued in the current or last run, 0..16.

Function
REQ-014 SHALL contain a 16 x 4-bit program memory, written on a rising edge when LoadEn=1 and Busy=0; LoadEn while Busy=1 SHALL be ignored.
REQ-015 SHALL implement states IDLE, FETCH, ISSUE and DONE.
REQ-016 IDLE: Start=1 SHALL clear PC and InstrCount and enter FETCH next cycle; Start while Busy=1 SHALL be ignored.
REQ-017 Start and LoadEn in the same IDLE cycle SHALL both take effect; the write SHALL be visible to the first fetch.
REQ-018 FETCH: SHALL latch mem[PC] into an internal instruction register and enter ISSUE next cycle.
REQ-019 ISSUE with opcode 4'b1111 (HALT) SHALL NOT assert InstrValid, SHALL NOT increment InstrCount, and SHALL enter DONE.
REQ-020 ISSUE with any other opcode SHALL drive Instruction=opcode and InstrValid=1 for that one cycle and increment InstrCount.
REQ-021 After a non-HALT ISSUE, if PC=15 the block SHALL enter DONE with PC held at 15 (no wrap); otherwise PC SHALL increment and the block SHALL enter FETCH.
REQ-022 Throughput SHALL be one issued opcode per two cycles; Start-to-first-InstrValid latency SHALL be 2 cycles.
REQ-023 DONE: Done=1 for one cycle, then IDLE; PC and InstrCount SHALL hold until the next Start.
REQ-024 When InstrValid=0, Instruction SHALL be 4'b1100 (decoder no-op: all enables low).
REQ-025 Abort=1 in any non-IDLE state SHALL force IDLE next cycle, with InstrValid=0 and Done=0; Abort SHALL take priority over every other transition.
REQ-026 Opcodes 4'b1100-4'b1110 SHALL be issued like any other opcode (InstrValid=1).

Reset
REQ-027 Reset_n=0 SHALL asynchronously force state=IDLE, PC=0, InstrCount=0, Instruction=4'b1100, InstrValid=0, Busy=0, Done=0.
REQ-028 Program memory contents SHALL NOT be cleared by reset.
REQ-029 Reset asserted mid-run SHALL abandon the run; after release, the block SHALL wait for Start.

Configuration
REQ-030 With SEQ_SINGLE_STEP_EN defined, the block SHALL add a 1-bit input Step and a state WAIT_STEP between FETCH and ISSUE; it SHALL leave WAIT_STEP only on a cycle with Step=1 (or Abort).
REQ-031 With SEQ_SINGLE_STEP_EN defined, Step outside WAIT_STEP SHALL be ignored, and HALT SHALL also require Step before DONE.
REQ-032 Without SEQ_SINGLE_STEP_EN, the block SHALL have no Step port and SHALL follow REQ-022 timing.

Verification
REQ-033 Load mem[0..3]=0000,0001,0010,0100, mem[4]=1111; Start -> InstrValid on cycles 2,4,6,8 with those opcodes; Done at cycle 10; InstrCount=4; PC=4.
REQ-034 Load all 16 entries with 0101, then Start -> 16 InstrValid pulses, Done after the last, PC=15, InstrCount=16, no wrap.
REQ-035 Abort one cycle after the second InstrValid -> Busy=0 next cycle, Done never asserted, InstrCount=2.
REQ-036 LoadEn to mem[0]=0011 while Busy=1 -> the write is ignored, and the next run issues the old mem[0].
REQ-037 Reset_n low during ISSUE -> all outputs at reset values immediately, and program memory is intact on the following run.
REQ-038 SEQ_SINGLE_STEP_EN defined with Step held low -> no InstrValid and PC stable; one Step pulse -> exactly one InstrValid.
